multicycle_div: RTL and testbench
=================================

MULTICYCLE_DIV -- requirements
Module: multicycle_div

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 is_signed  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 flush  input  1  synchronous cancel of an in-flight divide.
REQ-007 dividend  input  WIDTH  numerator; sampled with start.
REQ-008 divisor  input  WIDTH  denominator; sampled with start.
REQ-009 busy  output  1  high while a divide is in flight.
REQ-010 done  output  1  one-cycle pulse; hi/lo/div_by_zero valid in that cycle.
REQ-011 div_by_zero  output  1  high with done when the sampled divisor was 0; holds until next accepted start.
REQ-012 hi  output  WIDTH  remainder register.
REQ-013 lo  output  WIDTH  quotient register.

Function
REQ-014 The block SHALL implement states IDLE, RUN, FIX; reset and flush force IDLE.
REQ-015 In IDLE with start=1 and divisor!=0, the block SHALL latch operands/mode, load |dividend| and |divisor| (magnitudes only when is_signed=1), clear partial remainder/quotient, set iteration counter to WIDTH, enter RUN, assert busy.
REQ-016 In IDLE with start=1 and divisor=0, the block SHALL stay in IDLE, pulse done next cycle with div_by_zero=1, keep busy=0, and leave hi/lo unchanged.
REQ-017 RUN SHALL perform one restoring step per cycle, MSB first: shift remainder left, insert next dividend bit, subtract divisor magnitude if remainder >= divisor, set quotient bit; counter decrements; after WIDTH steps enter FIX.
REQ-018 FIX SHALL write lo = quotient negated iff is_signed and operand signs differ; hi = remainder negated iff is_signed and dividend negative; pulse done, clear div_by_zero, drop busy, return to IDLE.
REQ-019 Latency: start accepted on edge E0 -> done high in the cycle after edge E(WIDTH+1); busy high from after E0 through E(WIDTH+1).
REQ-020 Quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign; |hi| < |divisor|.
REQ-021 Signed most-negative / -1 SHALL give lo = most-negative value (wrap), hi = 0, no error flag.
REQ-022 Internal magnitude arithmetic SHALL be WIDTH+1 bits so that |most-negative| is exact.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the in-flight divide.
REQ-024 flush while busy SHALL abandon the divide in the next cycle: no done, hi/lo/div_by_zero unchanged; flush and start in the same IDLE cycle: flush wins, start ignored.
REQ-025 hi/lo SHALL change only in the FIX cycle and hold otherwise.
REQ-026 A new start SHALL be accepted in the same cycle done is high (back-to-back issue).

Reset
REQ-027 On reset: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0, internal registers 0.
REQ-028 Reset during RUN or FIX SHALL abort the divide with no done pulse; reset overrides start and flush.

Structure
REQ-029 Package div_pkg SHALL hold the state enum (IDLE/RUN/FIX) and DIV_WIDTH_DEFAULT=32.
REQ-030 One sub-module div_step (combinational single restoring iteration, parametrised WIDTH) SHALL be instantiated once inside RUN datapath.
REQ-031 Counter width SHALL be $clog2(WIDTH+1) bits.

Verification
REQ-032 Signed 7 / 2 (WIDTH=32) -> done after 33 edges, lo=0x00000003, hi=0x00000001, div_by_zero=0.
REQ-033 Signed -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-034 Unsigned 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F; same operands signed -> lo=0, hi=0xFFFFFFFF.
REQ-035 Divisor 0 with prior hi=0x5, lo=0x9 -> done and div_by_zero=1 one cycle after start, busy never high, hi/lo still 0x5/0x9.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then start asserted on done cycle with 100/7 -> lo=14, hi=2.
REQ-037 Start 100/7, second start mid-RUN ignored, flush at cycle 10 -> no done, busy=0 next cycle, hi/lo unchanged; reset at cycle 5 of a new divide -> all outputs 0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the multicycle divider.
//   div_state_e        : controller states (IDLE, RUN, FIX)
//   DIV_WIDTH_DEFAULT  : default operand/result width
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division iteration.
//   rem_in  [WIDTH:0] : partial remainder before this step (always < dvs)
//   bit_in            : next dividend bit, MSB first
//   dvs     [WIDTH:0] : divisor magnitude
//   rem_out [WIDTH:0] : partial remainder after this step
//   q_bit             : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  // One guard bit above the shifted remainder lets the subtraction borrow
  // double as the "remainder >= divisor" compare.
  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Shift, trial-subtract, restore when the subtraction borrows.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, dvs};
    if (diff_s[WIDTH+1] == 1'b0) begin
      rem_out = diff_s[WIDTH:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_div.sv
// multicycle_div -- iterative restoring divider, signed (DIV) or unsigned
// (DIVU), one quotient bit per cycle, WIDTH+2 cycles per divide.
//   clk, reset (sync, active-high)
//   start, is_signed, dividend, divisor : request, sampled while busy=0
//   flush        : cancel an in-flight divide (wins over start)
//   busy         : divide in flight
//   done         : one-cycle pulse, results valid
//   div_by_zero  : sampled divisor was 0; held until next accepted start
//   hi / lo      : remainder / quotient, updated only when a divide completes
module multicycle_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Dividend magnitude: WIDTH bits as an unsigned value is already exact,
  // including |most-negative| = 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      mag_w = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_w = v;
    end
  endfunction

  // Divisor magnitude, sign-extended to WIDTH+1 bits before negation.
  function automatic logic [WIDTH:0] mag_x(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH:0] ext;
    ext = {neg, v};
    if (neg) begin
      mag_x = (~ext) + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      mag_x = ext;
    end
  endfunction

  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r;      // dividend magnitude, shifted out MSB first
  logic [WIDTH:0]   dvs_r;      // divisor magnitude
  logic [WIDTH:0]   rem_r;      // partial remainder
  logic [WIDTH-1:0] quo_r;      // partial quotient
  logic             signed_r;
  logic             dvd_neg_r;
  logic             dvs_neg_r;

  logic [WIDTH:0]   step_rem_s;
  logic             step_q_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] lo_fix_s;
  logic [WIDTH-1:0] hi_fix_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .dvs     (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Operand signs only matter in signed mode.
  always_comb begin
    dvd_neg_s = is_signed & dividend[WIDTH-1];
    dvs_neg_s = is_signed & divisor[WIDTH-1];
  end

  // Sign fix-up of the magnitude results.
  always_comb begin
    lo_fix_s = quo_r;
    hi_fix_s = rem_r[WIDTH-1:0];
    if (signed_r && (dvd_neg_r != dvs_neg_r)) begin
      lo_fix_s = (~quo_r) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      lo_fix_s = quo_r;
    end
    if (signed_r && dvd_neg_r) begin
      hi_fix_s = (~rem_r[WIDTH-1:0]) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      hi_fix_s = rem_r[WIDTH-1:0];
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      signed_r    <= 1'b0;
      dvd_neg_r   <= 1'b0;
      dvs_neg_r   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abandon silently: results and error flag keep their old values.
        state_r <= IDLE;
        cnt_r   <= '0;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              if (divisor == '0) begin
                // Reported immediately without entering RUN.
                done        <= 1'b1;
                div_by_zero <= 1'b1;
              end else begin
                dvd_r       <= mag_w(dividend, dvd_neg_s);
                dvs_r       <= mag_x(divisor, dvs_neg_s);
                rem_r       <= '0;
                quo_r       <= '0;
                signed_r    <= is_signed;
                dvd_neg_r   <= dvd_neg_s;
                dvs_neg_r   <= dvs_neg_s;
                cnt_r       <= CNT_LOAD;
                div_by_zero <= 1'b0;
                busy        <= 1'b1;
                state_r     <= RUN;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          RUN: begin
            rem_r <= step_rem_s;
            quo_r <= {quo_r[WIDTH-2:0], step_q_s};
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= FIX;
            end else begin
              state_r <= RUN;
            end
          end
          FIX: begin
            lo          <= lo_fix_s;
            hi          <= hi_fix_s;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_div.sv
module tb_multicycle_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic         flush;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  // Expected contents of hi/lo as seen from outside.
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  multicycle_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .flush       (flush),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] e_hi, output logic [W-1:0] e_lo, output logic e_dbz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'd0) begin
      e_dbz = 1'b1;
      e_hi  = model_hi;
      e_lo  = model_lo;
    end else if (sgn) begin
      e_dbz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      e_lo = sq[W-1:0];
      e_hi = sr[W-1:0];
    end else begin
      e_dbz = 1'b0;
      ua = {32'd0, a};
      ub = {32'd0, b};
      uq = ua / ub;
      ur = ua % ub;
      e_lo = uq[W-1:0];
      e_hi = ur[W-1:0];
    end
  endtask

  // Issue one divide at posedge+1 and wait for done; returns in the done cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input string tag);
    logic [W-1:0] e_hi, e_lo;
    logic         e_dbz;
    int           k;
    int           hold_bad;
    int           exp_lat;
    ref_div(a, b, sgn, e_hi, e_lo, e_dbz);
    exp_lat   = e_dbz ? 0 : W + 1;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== !e_dbz || div_by_zero !== e_dbz)
      $display("FAIL %s accept: busy=%b dbz=%b want busy=%b dbz=%b", tag, busy, div_by_zero, !e_dbz, e_dbz);
    k = 0;
    hold_bad = 0;
    while (done !== 1'b1 && k < 100) begin
      if (hi !== model_hi || lo !== model_lo || busy !== 1'b1) hold_bad++;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, k, exp_lat);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL %s hold: %0d cycles with hi/lo changed or busy low, want 0", tag, hold_bad);
    end
    checks++;
    if (hi !== e_hi || lo !== e_lo || div_by_zero !== e_dbz || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h dbz=%b busy=%b want hi=%h lo=%h dbz=%b busy=0",
               tag, hi, lo, div_by_zero, busy, e_hi, e_lo, e_dbz);
    end
    model_hi = e_hi;
    model_lo = e_lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: busy=%b done=%b dbz=%b want 0 0 0", busy, done, div_by_zero);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset hilo: hi=%h lo=%h want 0 0", hi, lo);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    issue(32'd7, 32'd2, 1'b1, "s7div2");
    checks++;
    if (lo !== 32'h00000003 || hi !== 32'h00000001) begin
      errors++;
      $display("FAIL s7div2 const: lo=%h hi=%h want 00000003 00000001", lo, hi);
    end
    issue(32'hFFFFFFF9, 32'd2, 1'b1, "sm7div2");
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL sm7div2 const: lo=%h hi=%h want fffffffd ffffffff", lo, hi);
    end
    issue(32'd7, 32'hFFFFFFFE, 1'b1, "s7divm2");
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
      errors++;
      $display("FAIL s7divm2 const: lo=%h hi=%h want fffffffd 00000001", lo, hi);
    end
    issue(32'hFFFFFFFF, 32'h10, 1'b0, "uffdiv16");
    checks++;
    if (lo !== 32'h0FFFFFFF || hi !== 32'h0000000F) begin
      errors++;
      $display("FAIL uffdiv16 const: lo=%h hi=%h want 0fffffff 0000000f", lo, hi);
    end
    issue(32'hFFFFFFFF, 32'h10, 1'b1, "sffdiv16");
    checks++;
    if (lo !== 32'h00000000 || hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL sffdiv16 const: lo=%h hi=%h want 00000000 ffffffff", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    issue(32'd68, 32'd7, 1'b0, "prime59");
    issue(32'd123, 32'd0, 1'b1, "divzero");
    checks++;
    if (hi !== 32'h5 || lo !== 32'h9) begin
      errors++;
      $display("FAIL divzero keep: hi=%h lo=%h want 5 9", hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (div_by_zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero sticky: dbz=%b done=%b busy=%b want 1 0 0", div_by_zero, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, "minneg");
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++;
      $display("FAIL minneg const: lo=%h hi=%h want 80000000 0", lo, hi);
    end
    // Still in the done cycle: the next start goes in right now.
    issue(32'd100, 32'd7, 1'b0, "b2b");
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL b2b const: lo=%0d hi=%0d want 14 2", lo, hi);
    end
  endtask

  task automatic test_start_while_busy();
    int k;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    repeat (3) begin @(posedge clk); #1; k++; end
    start = 1'b1; dividend = 32'd50; divisor = 32'd3; is_signed = 1'b1;
    @(posedge clk); #1; k++;
    start = 1'b0;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (k !== W + 1 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d lo=%0d hi=%0d want %0d 14 2", k, lo, hi, W + 1);
    end
    model_hi = 32'd2;
    model_lo = 32'd14;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int done_seen;
    int changed;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush drop: busy=%b done=%b want 0 0", busy, done);
    end
    done_seen = 0;
    changed = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      if (hi !== model_hi || lo !== model_lo || div_by_zero !== 1'b0) changed++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_seen !== 0 || changed !== 0) begin
      errors++;
      $display("FAIL flush quiet: activity=%0d changed=%0d want 0 0", done_seen, changed);
    end
    start = 1'b1; flush = 1'b1; dividend = 32'd5; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int activity;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    model_hi = '0;
    model_lo = '0;
    activity = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) activity++;
      @(posedge clk); #1;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("FAIL reset_mid quiet: %0d active cycles want 0", activity);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         s;
    int           mode;
    for (int i = 0; i < 60; i++) begin
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
        2: b = 32'd1;
        3: b = 32'($urandom_range(1, 255));
        4: b = -32'($urandom_range(1, 255));
        default: b = b;
      endcase
      issue(a, b, s, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_start_while_busy();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
